pcie_cfg_apb_ctrl: RTL

PCIE_CFG_APB_CTRL -- requirements
Module: pcie_cfg_apb_ctrl

---
 rtl/pcie_cfg_apb_ctrl_if.sv | 22 ++
 rtl/pcie_cfg_apb_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pcie_cfg_apb_ctrl_if.sv
// APB register-access bus for the PCIe configuration request controller.
// pready is part of the bus; this slave always completes in the access cycle.
interface pcie_cfg_apb_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pcie_cfg_apb_ctrl.sv
// APB-programmed PCIe configuration request issuer: holds request fields, raises tx_en for
// one request, captures the completion or a timeout, and reports status/interrupt.
module pcie_cfg_apb_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 pclk_div2,
  input  logic                 apb_rst_n,
  pcie_cfg_apb_ctrl_if.slave   apb,
  output logic                 pcie_cfg_fmt,
  output logic                 pcie_cfg_type,
  output logic [7:0]           pcie_cfg_tag,
  output logic [3:0]           pcie_cfg_fbe,
  output logic [15:0]          pcie_cfg_des_id,
  output logic [9:0]           pcie_cfg_reg_num,
  output logic [31:0]          pcie_cfg_tx_data,
  output logic                 tx_en,
  input  logic                 pcie_cfg_cpl_rcv,
  input  logic [2:0]           pcie_cfg_cpl_status,
  input  logic [31:0]          pcie_cfg_rx_data,
  output logic                 irq
);

  localparam logic [7:0]  AddrCtrl    = 8'h00;
  localparam logic [7:0]  AddrAddr    = 8'h04;
  localparam logic [7:0]  AddrWdata   = 8'h08;
  localparam logic [7:0]  AddrRdata   = 8'h0C;
  localparam logic [7:0]  AddrStatus  = 8'h10;
  localparam logic [7:0]  AddrTag     = 8'h14;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic        fmt_q, type_q, irq_en_q;
  logic [3:0]  fbe_q;
  logic [15:0] des_id_q;
  logic [9:0]  reg_num_q;
  logic [31:0] wdata_q, rdata_q;
  logic        done_q, timeout_q;
  logic [2:0]  cpl_status_q;
  logic [7:0]  tag_q;
  logic        irq_q;

  logic        access, wr, busy, mapped, read_only;
  logic [31:0] rd_data;
  logic        cfg_wr, ctrl_wr, addr_wr, wdata_wr, status_wr, start;
  logic        timer_hit, cpl_take, tmo_take;

  assign access    = apb.psel & apb.penable;
  assign wr        = access & apb.pwrite;
  assign busy      = (state_q != StIdle);

  always_comb begin
    rd_data   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (apb.paddr)
      AddrCtrl:   rd_data = {23'b0, irq_en_q, fbe_q, 1'b0, type_q, fmt_q, 1'b0};
      AddrAddr:   rd_data = {6'b0, reg_num_q, des_id_q};
      AddrWdata:  rd_data = wdata_q;
      AddrRdata: begin
        rd_data   = rdata_q;
        read_only = 1'b1;
      end
      AddrStatus: rd_data = {25'b0, cpl_status_q, 1'b0, timeout_q, done_q, busy};
      AddrTag: begin
        rd_data   = {24'b0, tag_q};
        read_only = 1'b1;
      end
      default:    mapped = 1'b0;
    endcase
  end

  assign apb.prdata  = (access && !apb.pwrite) ? rd_data : '0;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = access & (~mapped | (apb.pwrite & read_only));

  // Request-field registers are frozen while a request is outstanding.
  assign cfg_wr    = wr & ~busy;
  assign ctrl_wr   = cfg_wr & (apb.paddr == AddrCtrl);
  assign addr_wr   = cfg_wr & (apb.paddr == AddrAddr);
  assign wdata_wr  = cfg_wr & (apb.paddr == AddrWdata);
  assign status_wr = wr & (apb.paddr == AddrStatus);
  assign start     = ctrl_wr & apb.pwdata[0];

  assign timer_hit = (cnt_q == TimeoutLast);
  assign cpl_take  = (state_q == StReq) & pcie_cfg_cpl_rcv;
  assign tmo_take  = (state_q == StReq) & ~pcie_cfg_cpl_rcv & timer_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (pcie_cfg_cpl_rcv || timer_hit) state_d = StHold;
      StHold:  if (cnt_q == 16'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      cnt_q        <= '0;
      fmt_q        <= 1'b0;
      type_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      fbe_q        <= '0;
      des_id_q     <= '0;
      reg_num_q    <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cpl_status_q <= '0;
      tag_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      // One counter serves both the REQ timeout and the HOLD length.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (ctrl_wr) begin
        fmt_q    <= apb.pwdata[1];
        type_q   <= apb.pwdata[2];
        fbe_q    <= apb.pwdata[7:4];
        irq_en_q <= apb.pwdata[8];
      end
      if (addr_wr) begin
        des_id_q  <= apb.pwdata[15:0];
        reg_num_q <= apb.pwdata[25:16];
      end
      if (wdata_wr) begin
        wdata_q <= apb.pwdata;
      end
      if (start) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        tag_q     <= tag_q + 8'd1;
      end else begin
        if (status_wr && apb.pwdata[1]) done_q <= 1'b0;
        if (status_wr && apb.pwdata[2]) timeout_q <= 1'b0;
        // Later assignments win, so a same-cycle set beats the W1C.
        if (cpl_take) begin
          done_q       <= 1'b1;
          rdata_q      <= pcie_cfg_rx_data;
          cpl_status_q <= pcie_cfg_cpl_status;
        end else if (tmo_take) begin
          done_q       <= 1'b1;
          timeout_q    <= 1'b1;
          rdata_q      <= '1;
          cpl_status_q <= 3'b111;
        end
      end
      irq_q <= irq_en_q & done_q;
    end
  end

  assign pcie_cfg_fmt     = fmt_q;
  assign pcie_cfg_type    = type_q;
  assign pcie_cfg_tag     = tag_q;
  assign pcie_cfg_fbe     = fbe_q;
  assign pcie_cfg_des_id  = des_id_q;
  assign pcie_cfg_reg_num = reg_num_q;
  assign pcie_cfg_tx_data = wdata_q;
  assign tx_en            = (state_q == StReq);
  assign irq              = irq_q;

endmodule
